// File: rtl/pulse_width_meter_pkg.sv
// ---------------------------------------------------------------------------
// pulse_width_meter_pkg
//   Shared types, constants and helpers for the pulse width meter.
//   - PW_CNT_W : default segment-counter width
//   - CNT_MAX  : all-ones value of a default-width counter
//   - pw_rec_t : one measured segment {level, sat, width}
//   - sat_inc  : increment that sticks at a caller-supplied ceiling
// ---------------------------------------------------------------------------
package pulse_width_meter_pkg;

    localparam int unsigned PW_CNT_W = 8;

    localparam logic [PW_CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                level;
        logic                sat;
        logic [PW_CNT_W-1:0] width;
    } pw_rec_t;

    // Saturating increment; callers narrow the result back to their own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] ceiling);
        if (value >= ceiling) begin
            return ceiling;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/pulse_width_meter_if.sv
// ---------------------------------------------------------------------------
// pulse_width_meter_if
//   Valid/ready record stream leaving the pulse width meter.
//   - m_valid : a record is presented
//   - m_ready : sink accepts the record when m_valid && m_ready
//   - m_level : level of the measured segment (1 = high pulse, 0 = low gap)
//   - m_width : segment length in clk cycles, saturating
//   - m_sat   : segment length reached the counter ceiling
//   Modports: master (meter side), slave (sink side).
// ---------------------------------------------------------------------------
interface pulse_width_meter_if #(
    parameter int unsigned CNT_W = 8
);

    logic             m_valid;
    logic             m_ready;
    logic             m_level;
    logic [CNT_W-1:0] m_width;
    logic             m_sat;

    modport master (
        output m_valid,
        output m_level,
        output m_width,
        output m_sat,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_level,
        input  m_width,
        input  m_sat,
        output m_ready
    );

endinterface

// File: rtl/pulse_width_meter_fifo.sv
// ---------------------------------------------------------------------------
// pw_fifo
//   Synchronous first-word-fall-through FIFO for packed segment records.
//   - clk, rst_n : clock, asynchronous active-low reset
//   - push_i     : write request with wdata_i
//   - pop_i      : read request; ignored while empty
//   - rdata_o    : head entry, forced to zero while empty
//   - empty_o    : no entries stored
//   - full_o     : DEPTH entries stored
//   - drop_o     : push_i refused (full and no pop this cycle)
//   A push while empty is written and shows at the head one cycle later;
//   there is no combinational bypass from wdata_i to rdata_o.
// ---------------------------------------------------------------------------
module pw_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             drop_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        // A full FIFO still takes a push when the head leaves in the same cycle.
        do_push  = push_i && (!full_o || do_pop);
        drop_o   = push_i && full_o && !do_pop;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
        end
    end

endmodule

// File: rtl/pulse_width_meter.sv
// ---------------------------------------------------------------------------
// pulse_width_meter
//   Synchronises an asynchronous 1-bit line, times every completed high or
//   low segment in clk cycles and queues {level, sat, width} records.
//   - clk     : single clock, rising edge
//   - rst_n   : asynchronous active-low reset
//   - in      : monitored line, asynchronous to clk
//   - m       : record stream (master modport of pulse_width_meter_if)
//   - overflow: sticky, a record was dropped because the FIFO was full
//   - clr_ovf : synchronous clear of overflow (a same-cycle drop wins)
//   The segment in progress at reset has no known start and is never
//   reported; counting is armed by the first level change afterwards.
// ---------------------------------------------------------------------------
module pulse_width_meter
    import pulse_width_meter_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = PW_CNT_W,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in,
    pulse_width_meter_if.master     m,
    output logic                    overflow,
    input  logic                    clr_ovf
);

    localparam int unsigned      REC_W    = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_ONES = '1;

    logic [SYNC_STAGES-1:0] sync_q,  sync_d;
    logic                   in_s;
    logic                   in_d_q;
    logic                   lvl_chg;
    logic [CNT_W-1:0]       cnt_q,   cnt_d;
    logic                   armed_q, armed_d;
    logic                   push_q,  push_d;
    logic [REC_W-1:0]       rec_q,   rec_d;
    logic                   ovf_q,   ovf_d;

    logic [REC_W-1:0]       head;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   fifo_drop;

    assign in_s    = sync_q[SYNC_STAGES-1];
    assign lvl_chg = (in_s != in_d_q);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], in};

        armed_d = armed_q;
        if (lvl_chg) begin
            cnt_d   = CNT_W'(1);
            armed_d = 1'b1;
        end else begin
            cnt_d   = CNT_W'(sat_inc(32'(cnt_q), 32'(CNT_ONES)));
        end

        // The record is staged one cycle before the FIFO write, so a change
        // on the line reaches m_valid SYNC_STAGES+1 edges after capture.
        push_d  = lvl_chg && armed_q;
        rec_d   = {in_d_q, (cnt_q == CNT_ONES), cnt_q};

        ovf_d   = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            in_d_q  <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            push_q  <= 1'b0;
            rec_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            in_d_q  <= in_s;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            push_q  <= push_d;
            rec_q   <= rec_d;
            ovf_q   <= ovf_d;
        end
    end

    pw_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .wdata_i (rec_q),
        .pop_i   (m.m_ready),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .drop_o  (fifo_drop)
    );

    assign m.m_valid = !fifo_empty;
    assign m.m_level = head[CNT_W+1];
    assign m.m_sat   = head[CNT_W];
    assign m.m_width = head[CNT_W-1:0];
    assign overflow  = ovf_q;

    // A record can only be refused by a full FIFO.
    drop_needs_full: assert property (@(posedge clk) disable iff (!rst_n)
                                      fifo_drop |-> fifo_full);

endmodule

// File: tb/tb_pulse_width_meter.sv
module tb_pulse_width_meter;
    import pulse_width_meter_pkg::*;

    logic clk;
    logic rst_n;
    logic in_line;
    logic overflow;
    logic clr_ovf;

    pulse_width_meter_if #(.CNT_W(PW_CNT_W)) mif ();

    pulse_width_meter #(
        .SYNC_STAGES (2),
        .CNT_W       (PW_CNT_W),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (in_line),
        .m        (mif),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int      total = 0;
    int      bad   = 0;
    int      n_acc = 0;
    int      low_run = 0;
    logic    rdy_rand = 1'b0;
    pw_rec_t exp_q[$];
    pw_rec_t mon_e;

    typedef struct {
        logic        lvl;
        int unsigned len;
        logic        rep;
        logic        e_sat;
        int unsigned e_width;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    function automatic pw_rec_t cur_rec();
        pw_rec_t r;
        r.level = mif.m_level;
        r.sat   = mif.m_sat;
        r.width = mif.m_width;
        return r;
    endfunction

    function automatic pw_rec_t mk(input logic lvl, input logic sat, input int unsigned w);
        pw_rec_t r;
        r.level = lvl;
        r.sat   = sat;
        r.width = PW_CNT_W'(w);
        return r;
    endfunction

    // Reference: a segment lasting n cycles reports min(n, 2^W-1), sat when n reaches it.
    function automatic pw_rec_t model_rec(input logic lvl, input int unsigned n);
        int unsigned ceil_v = (1 << PW_CNT_W) - 1;
        return mk(lvl, n >= ceil_v, (n >= ceil_v) ? ceil_v : n);
    endfunction

    // Monitor: every accepted record must be the oldest outstanding expectation.
    always @(negedge clk) begin
        #1;
        if (rst_n && mif.m_valid && mif.m_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rec_unexpected: got %0h, expected no record", cur_rec());
            end else begin
                mon_e = exp_q.pop_front();
                chk("rec", 32'(cur_rec()), 32'(mon_e));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (rdy_rand) begin
            if (low_run >= 2) mif.m_ready = 1'b1;
            else              mif.m_ready = 1'($urandom_range(0, 1));
            low_run = mif.m_ready ? 0 : low_run + 1;
        end
    endtask

    // Hold the line at lvl for n clk cycles; queue the expected record when reported.
    task automatic seg(input logic lvl, input int unsigned n, input logic rep, input pw_rec_t e);
        step();
        in_line = lvl;
        if (rep) exp_q.push_back(e);
        repeat (n - 1) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_line = 1'b0;
        mif.m_ready = 1'b0;
        clr_ovf = 1'b0;
        rdy_rand = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        logic lvl;
        int unsigned n;
        rst_n = 1'b0;
        in_line = 1'b0;
        clr_ovf = 1'b0;
        mif.m_ready = 1'b0;

        tbl[0]  = '{1'b0, 20,  1'b0, 1'b0, 0};
        tbl[1]  = '{1'b1, 5,   1'b1, 1'b0, 5};
        tbl[2]  = '{1'b0, 10,  1'b1, 1'b0, 10};
        tbl[3]  = '{1'b1, 300, 1'b1, 1'b1, 255};
        tbl[4]  = '{1'b0, 7,   1'b1, 1'b0, 7};
        tbl[5]  = '{1'b1, 1,   1'b1, 1'b0, 1};
        tbl[6]  = '{1'b0, 12,  1'b1, 1'b0, 12};
        tbl[7]  = '{1'b1, 255, 1'b1, 1'b1, 255};
        tbl[8]  = '{1'b0, 254, 1'b1, 1'b0, 254};
        tbl[9]  = '{1'b1, 2,   1'b1, 1'b0, 2};
        tbl[10] = '{1'b0, 30,  1'b0, 1'b0, 0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid",    32'(mif.m_valid), 0);
        chk("rst_rec",      32'(cur_rec()),   0);
        chk("rst_overflow", 32'(overflow),    0);
        rst_n = 1'b1;
        mif.m_ready = 1'b1;

        // Directed table: widths, saturation boundaries, 1-cycle glitch
        for (int i = 0; i < 11; i++) begin
            seg(tbl[i].lvl, tbl[i].len, tbl[i].rep, mk(tbl[i].lvl, tbl[i].e_sat, tbl[i].e_width));
            if (i == 0) chk("no_rec_before_first_edge", 32'(mif.m_valid), 0);
        end
        chk("table_drained", 32'(exp_q.size()), 0);

        // Latency: capture at edge t -> m_valid after t+3, for one cycle
        @(negedge clk);
        in_line = 1'b1;
        exp_q.push_back(mk(1'b0, 1'b0, 30));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_t%0d", k), 32'(mif.m_valid), 32'(k == 3));
        end
        repeat (3) @(negedge clk);
        chk("latency_drained", 32'(exp_q.size()), 0);

        // Overflow with stalled sink, clear, and clear-versus-drop
        do_reset();
        seg(1'b0, 4,  1'b0, '0);
        seg(1'b1, 3,  1'b1, mk(1'b1, 1'b0, 3));
        seg(1'b0, 4,  1'b1, mk(1'b0, 1'b0, 4));
        seg(1'b1, 5,  1'b1, mk(1'b1, 1'b0, 5));
        seg(1'b0, 3,  1'b1, mk(1'b0, 1'b0, 3));
        seg(1'b1, 4,  1'b0, '0);
        seg(1'b0, 6,  1'b0, '0);
        seg(1'b1, 12, 1'b0, '0);
        chk("ovf_set",        32'(overflow),    1);
        chk("ovf_head_hold",  32'(cur_rec()),   32'(mk(1'b1, 1'b0, 3)));
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        chk("ovf_cleared",    32'(overflow),    0);
        chk("ovf_head_hold2", 32'(cur_rec()),   32'(mk(1'b1, 1'b0, 3)));
        @(negedge clk); in_line = 1'b0;
        repeat (3) @(negedge clk);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("drop_beats_clear", 32'(overflow), 1);
        @(negedge clk);
        chk("ovf_sticky",       32'(overflow), 1);
        mif.m_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("ovf_drained",       32'(exp_q.size()), 0);
        chk("ovf_empty_after",   32'(mif.m_valid),  0);

        // Full FIFO with pop on the push cycle: no drop
        do_reset();
        seg(1'b0, 4, 1'b0, '0);
        seg(1'b1, 3, 1'b1, mk(1'b1, 1'b0, 3));
        seg(1'b0, 3, 1'b1, mk(1'b0, 1'b0, 3));
        seg(1'b1, 4, 1'b1, mk(1'b1, 1'b0, 4));
        seg(1'b0, 5, 1'b1, mk(1'b0, 1'b0, 5));
        seg(1'b1, 6, 1'b1, mk(1'b1, 1'b0, 6));
        @(negedge clk); in_line = 1'b0;
        repeat (3) @(negedge clk);
        mif.m_ready = 1'b1;
        @(negedge clk);
        mif.m_ready = 1'b0;
        chk("full_pop_no_drop", 32'(overflow), 0);
        repeat (3) @(negedge clk);
        chk("full_still_valid", 32'(mif.m_valid), 1);
        chk("full_head_next",   32'(cur_rec()),   32'(mk(1'b0, 1'b0, 3)));
        n0 = n_acc;
        mif.m_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_count_4",     32'(n_acc - n0),   4);
        chk("full_drained",     32'(exp_q.size()), 0);
        chk("full_no_ovf",      32'(overflow),     0);

        // Mid-operation reset with two records buffered
        do_reset();
        seg(1'b0, 3, 1'b0, '0);
        seg(1'b1, 4, 1'b1, mk(1'b1, 1'b0, 4));
        seg(1'b0, 5, 1'b1, mk(1'b0, 1'b0, 5));
        @(negedge clk); in_line = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_rst_valid", 32'(mif.m_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(mif.m_valid), 0);
        chk("mid_rst_overflow", 32'(overflow),    0);
        chk("mid_rst_rec",      32'(cur_rec()),   0);
        exp_q.delete();
        @(negedge clk); in_line = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mif.m_ready = 1'b1;
        seg(1'b0, 6,  1'b0, '0);
        seg(1'b1, 9,  1'b1, mk(1'b1, 1'b0, 9));
        seg(1'b0, 8,  1'b1, mk(1'b0, 1'b0, 8));
        seg(1'b1, 20, 1'b0, '0);
        chk("post_rst_drained", 32'(exp_q.size()), 0);

        // Random segments against the reference model, sink stalls up to 2 cycles
        do_reset();
        rdy_rand = 1'b1;
        low_run = 0;
        lvl = 1'b0;
        seg(lvl, 5, 1'b0, '0);
        for (int i = 0; i < 60; i++) begin
            lvl = ~lvl;
            n = ($urandom_range(0, 15) == 0) ? $urandom_range(250, 270) : $urandom_range(3, 40);
            seg(lvl, n, 1'b1, model_rec(lvl, n));
        end
        seg(~lvl, 30, 1'b0, '0);
        rdy_rand = 1'b0;
        mif.m_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rand_drained",  32'(exp_q.size()), 0);
        chk("rand_no_ovf",   32'(overflow),     0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
